mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus-2 signal bundle between a line-transfer initiator and the memory responder.
//   a2_in  : line address from initiator
//   c2_in  : command from initiator
//   d2_in  : write data from initiator
//   c2_out : responder command drive, valid when c2_oe = 1
//   c2_oe  : responder owns the command lines
//   d2_out : responder read data drive, valid when d2_oe = 1
//   d2_oe  : responder owns the data lines
interface mem_responder_if #(
  parameter int unsigned ADDR2_BUS_SIZE = 10,
  parameter int unsigned DATA2_BUS_SIZE = 16,
  parameter int unsigned CTR2_BUS_SIZE  = 2
);
  logic [ADDR2_BUS_SIZE-1:0] a2_in;
  logic [CTR2_BUS_SIZE-1:0]  c2_in;
  logic [DATA2_BUS_SIZE-1:0] d2_in;
  logic [CTR2_BUS_SIZE-1:0]  c2_out;
  logic                      c2_oe;
  logic [DATA2_BUS_SIZE-1:0] d2_out;
  logic                      d2_oe;

  modport master (
    output a2_in, c2_in, d2_in,
    input  c2_out, c2_oe, d2_out, d2_oe
  );

  modport slave (
    input  a2_in, c2_in, d2_in,
    output c2_out, c2_oe, d2_out, d2_oe
  );
endinterface

// File: rtl/mem_responder.sv
// Line-oriented memory responder on bus 2. Accepts one read-line or write-line command
// at a time, stores whole cache lines and answers after a fixed latency.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (storage array is not cleared)
//   bus   : mem_responder_if slave modport (a2/c2/d2 inputs, c2/d2 outputs with enables)
module mem_responder #(
  parameter int unsigned ADDR2_BUS_SIZE  = 10,
  parameter int unsigned DATA2_BUS_SIZE  = 16,
  parameter int unsigned CTR2_BUS_SIZE   = 2,
  parameter int unsigned CACHE_LINE_SIZE = 16,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input logic             clk,
  input logic             rst_n,
  mem_responder_if.slave  bus
);

  localparam int unsigned Beats = CACHE_LINE_SIZE * 8 / DATA2_BUS_SIZE;
  localparam int unsigned Lines = 2 ** ADDR2_BUS_SIZE;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  // WAIT lasts MEM_LATENCY cycles counting down to zero.
  localparam logic [CntW-1:0]  LatInit  = CntW'(MEM_LATENCY - 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  // Beat k occupies bits [k*DATA2_BUS_SIZE +: DATA2_BUS_SIZE], i.e. little-endian bytes.
  typedef logic [Beats-1:0][DATA2_BUS_SIZE-1:0] line_t;

  typedef enum logic [2:0] {
    StIdle,
    StWriteBeats,
    StWait,
    StRespond,
    StTurn
  } state_e;

  state_e                    state_q, state_d;
  logic [BeatW-1:0]          beat_q, beat_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  logic                      wr_q, wr_d;

  line_t                     mem_q [Lines];
  line_t                     wbuf_q;
  line_t                     line_wr;
  line_t                     rd_line;
  logic [ADDR2_BUS_SIZE-1:0] wr_addr;
  logic                      capture;
  logic                      mem_we;

  logic [CTR2_BUS_SIZE-1:0]  c2_out;
  logic                      c2_oe;
  logic [DATA2_BUS_SIZE-1:0] d2_out;
  logic                      d2_oe;

  assign rd_line = mem_q[addr_q];

  // Line to commit: buffered beats with the beat on the bus this edge merged in.
  always_comb begin
    line_wr         = wbuf_q;
    line_wr[beat_q] = bus.d2_in;
  end

  // Single-beat lines commit straight from IDLE, before addr_q is loaded.
  assign wr_addr = (state_q == StIdle) ? bus.a2_in : addr_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    c2_out  = C2_NOP;
    c2_oe   = 1'b0;
    d2_out  = '0;
    d2_oe   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.c2_in == C2_READ_LINE) begin
          addr_d  = bus.a2_in;
          wr_d    = 1'b0;
          cnt_d   = LatInit;
          beat_d  = '0;
          state_d = StWait;
        end else if (bus.c2_in == C2_WRITE_LINE) begin
          addr_d  = bus.a2_in;
          wr_d    = 1'b1;
          cnt_d   = LatInit;
          capture = 1'b1;
          if (Beats > 1) begin
            beat_d  = BeatW'(1);
            state_d = StWriteBeats;
          end else begin
            mem_we  = 1'b1;
            beat_d  = '0;
            state_d = StWait;
          end
        end
      end

      StWriteBeats: begin
        capture = 1'b1;
        if (beat_q == LastBeat) begin
          mem_we  = 1'b1;
          beat_d  = '0;
          state_d = StWait;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      StWait: begin
        if (cnt_q == '0) begin
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StRespond: begin
        c2_out = C2_RESPONSE;
        c2_oe  = 1'b1;
        if (wr_q) begin
          state_d = StTurn;
        end else begin
          d2_oe  = 1'b1;
          d2_out = rd_line[beat_q];
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StTurn;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      StTurn: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // Storage and write buffer carry no reset: committed lines survive reset and a partial
  // write only ever touches the buffer.
  always_ff @(posedge clk) begin
    if (capture) begin
      wbuf_q[beat_q] <= bus.d2_in;
    end
    if (mem_we) begin
      mem_q[wr_addr] <= line_wr;
    end
  end

  assign bus.c2_out = c2_out;
  assign bus.c2_oe  = c2_oe;
  assign bus.d2_out = d2_out;
  assign bus.d2_oe  = d2_oe;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder with a byte-level line model.
module tb_mem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 2;
  localparam int unsigned LB  = 16;
  localparam int unsigned LAT = 4;
  localparam int unsigned B   = LB * 8 / DW;
  localparam int unsigned NB  = DW / 8;

  localparam logic [CW-1:0] NOP   = 2'b00;
  localparam logic [CW-1:0] RESP  = 2'b01;
  localparam logic [CW-1:0] READ  = 2'b10;
  localparam logic [CW-1:0] WRITE = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR2_BUS_SIZE(AW), .DATA2_BUS_SIZE(DW), .CTR2_BUS_SIZE(CW)) bus ();

  mem_responder #(
    .ADDR2_BUS_SIZE (AW),
    .DATA2_BUS_SIZE (DW),
    .CTR2_BUS_SIZE  (CW),
    .CACHE_LINE_SIZE(LB),
    .MEM_LATENCY    (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference storage: bytes of each line, plus whether the line has ever been written.
  logic [7:0] ref_mem [2**AW][LB];
  bit         ref_valid [2**AW];
  int         written [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_beat(int a, int k);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = ref_mem[a][k*NB + i];
    return r;
  endfunction

  // resp: responder should own c2; rd: responder should also own d2.
  task automatic check_ctl(string tag, bit resp, bit rd);
    logic [3:0] got;
    logic [3:0] exp;
    got = {bus.c2_oe, bus.d2_oe, bus.c2_out};
    exp = {resp, rd, resp ? RESP : NOP};
    check(tag, 32'(got), 32'(exp));
    if (!resp) check({tag, "_d0"}, 32'(bus.d2_out), 32'd0);
  endtask

  task automatic drive_junk(int mode);
    if (mode == 1) begin
      bus.c2_in = READ;
      bus.a2_in = 10'h3FF;
    end else begin
      bus.c2_in = CW'($urandom_range(0, 3));
      bus.a2_in = AW'($urandom);
    end
    bus.d2_in = DW'($urandom);
  endtask

  task automatic do_write(int addr, input logic [DW-1:0] data [B]);
    bus.c2_in = WRITE;
    bus.a2_in = AW'(addr);
    bus.d2_in = data[0];
    @(posedge clk);
    for (int k = 1; k < B; k++) begin
      @(negedge clk);
      check_ctl("wr_beat", 1'b0, 1'b0);
      bus.c2_in = CW'($urandom_range(0, 3));
      bus.a2_in = AW'($urandom);
      bus.d2_in = data[k];
      @(posedge clk);
    end
    for (int k = 0; k < B; k++)
      for (int i = 0; i < NB; i++) ref_mem[addr][k*NB + i] = data[k][8*i +: 8];
    if (!ref_valid[addr]) written.push_back(addr);
    ref_valid[addr] = 1'b1;
    for (int o = 0; o <= LAT + 1; o++) begin
      @(negedge clk);
      check_ctl("wr_resp", o == LAT, 1'b0);
      drive_junk(0);
      @(posedge clk);
    end
    @(negedge clk);
    check_ctl("wr_idle", 1'b0, 1'b0);
    bus.c2_in = NOP;
  endtask

  // rst_beat >= 0 pulls reset just after that read beat becomes visible.
  task automatic do_read(int addr, int junk_mode, int rst_beat);
    bus.c2_in = READ;
    bus.a2_in = AW'(addr);
    bus.d2_in = DW'($urandom);
    @(posedge clk);
    for (int o = 0; o <= LAT + B; o++) begin
      bit resp;
      @(negedge clk);
      resp = (o >= LAT) && (o < LAT + B);
      check_ctl("rd_ctl", resp, resp);
      if (resp && ref_valid[addr])
        check("rd_data", 32'(bus.d2_out), 32'(ref_beat(addr, o - LAT)));
      if (resp && (o - LAT == rst_beat)) begin
        #2 rst_n = 1'b0;
        bus.c2_in = NOP;
        #1 check_ctl("rst_async", 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_ctl("rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        return;
      end
      if (o == LAT + B) begin
        // Same command during TURN must be ignored; caller may re-issue it next edge.
        bus.c2_in = READ;
        bus.a2_in = AW'(addr);
      end else begin
        drive_junk(junk_mode);
      end
      @(posedge clk);
    end
    @(negedge clk);
    check_ctl("rd_idle", 1'b0, 1'b0);
    bus.c2_in = NOP;
  endtask

  task automatic write_abort(int addr, int nbeats);
    bus.c2_in = WRITE;
    bus.a2_in = AW'(addr);
    bus.d2_in = '1;
    @(posedge clk);
    for (int k = 1; k < nbeats; k++) begin
      @(negedge clk);
      bus.c2_in = CW'($urandom_range(0, 3));
      bus.d2_in = '1;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.c2_in = NOP;
    #1 check_ctl("abort_rst", 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pat [B];
    logic [DW-1:0] rnd [B];
    bus.c2_in = NOP;
    bus.a2_in = '0;
    bus.d2_in = '0;
    rst_n = 1'b0;
    #3 check_ctl("reset", 1'b0, 1'b0);
    bus.c2_in = READ;
    repeat (2) @(negedge clk);
    check_ctl("reset_clk", 1'b0, 1'b0);
    bus.c2_in = NOP;
    rst_n = 1'b1;

    for (int k = 0; k < B; k++) pat[k] = {8'(2*k + 1), 8'(2*k)};

    // Command right at reset release, known pattern, then reads around it.
    do_write(5, pat);
    do_read(5, 1, -1);
    do_read(5, 0, -1);
    do_read(5, 0, 3);
    do_read(5, 0, -1);
    write_abort(5, 4);
    do_read(5, 0, -1);
    check("line5_beat7", 32'(ref_beat(5, 7)), 32'h0F0E);

    // Address extremes.
    for (int k = 0; k < B; k++) rnd[k] = DW'($urandom);
    do_write(10'h3FF, rnd);
    for (int k = 0; k < B; k++) rnd[k] = DW'($urandom);
    do_write(0, rnd);
    do_read(10'h3FF, 0, -1);
    do_read(0, 0, -1);
    do_read(5, 0, -1);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < B; k++) rnd[k] = DW'($urandom);
        do_write(int'($urandom_range(0, 15)), rnd);
      end else begin
        do_read(written[$urandom_range(0, written.size() - 1)], 0, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
